param_stream: RTL and testbench

// Generic, parametrised parameter-fetch engine for the conv and dense datapaths.

---
 rtl/param_stream_if.sv | 25 ++
 rtl/param_stream.sv | 164 ++++++++++++++++
 tb/tb_param_stream.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/param_stream_if.sv
// Bundles the ROM read port and the output word stream of the parameter-fetch engine.
// master = engine side, slave = ROM/consumer side.
interface param_stream_if #(
  parameter int DWIDTH = 16*9,
  parameter int AWIDTH = 16
);
  logic              mem_en;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_dout;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_data;
  logic              out_last_i;
  logic              out_last;

  modport master (
    output mem_en, mem_addr, out_valid, out_data, out_last_i, out_last,
    input  mem_dout, out_ready
  );

  modport slave (
    input  mem_en, mem_addr, out_valid, out_data, out_last_i, out_last,
    output mem_dout, out_ready
  );
endinterface

// File: rtl/param_stream.sv
// Parameter-fetch engine: walks base + o*pitch + i over a synchronous ROM and streams
// the words through a credit-controlled FWFT buffer with full back-pressure.
module param_stream #(
  parameter int DWIDTH     = 16*9,
  parameter int AWIDTH     = 16,
  parameter int CWIDTH     = 8,
  parameter int MEM_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [AWIDTH-1:0] pitch,
  input  logic [CWIDTH-1:0] n_outer,
  input  logic [CWIDTH-1:0] n_inner,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  param_stream_if.master    bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_t;

  state_t              state_q, state_d;
  logic [AWIDTH-1:0]   row_base_q, row_base_d, pitch_q, pitch_d;
  logic [CWIDTH-1:0]   n_outer_q, n_outer_d, n_inner_q, n_inner_d;
  logic [CWIDTH-1:0]   o_q, o_d, i_q, i_d;
  logic [MEM_LAT-1:0]  vld_sr_q, vld_sr_d, lasti_sr_q, lasti_sr_d, last_sr_q, last_sr_d;
  logic [CW-1:0]       inflight_q, inflight_d, count_q, count_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DWIDTH+1:0]   fifo_mem_q [FIFO_DEPTH];

  logic                credit, issue, row_end, win_end, push, pop;
  logic [DWIDTH+1:0]   head;

  assign row_end = (i_q == n_inner_q - CWIDTH'(1));
  assign win_end = row_end && (o_q == n_outer_q - CWIDTH'(1));
  // Reads already issued still own a buffer slot, so the FIFO can never overflow.
  assign credit  = ({1'b0, inflight_q} + {1'b0, count_q}) < (CW+1)'(FIFO_DEPTH);
  assign push    = vld_sr_q[MEM_LAT-1];
  assign pop     = bus.out_valid && bus.out_ready;
  assign head    = fifo_mem_q[rd_ptr_q];

  assign bus.mem_en     = issue;
  assign bus.mem_addr   = row_base_q + AWIDTH'(i_q);
  assign bus.out_valid  = (count_q != '0);
  assign bus.out_data   = bus.out_valid ? head[DWIDTH-1:0] : '0;
  assign bus.out_last_i = bus.out_valid && head[DWIDTH];
  assign bus.out_last   = bus.out_valid && head[DWIDTH+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = (n_outer == '0 || n_inner == '0) ? S_FIN : S_ISSUE;
      S_ISSUE: if (issue && win_end) state_d = S_DRAIN;
      S_DRAIN: if (pop && head[DWIDTH+1]) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    issue = 1'b0;
    unique case (state_q)
      S_ISSUE: begin busy = 1'b1; issue = credit; end
      S_DRAIN: busy = 1'b1;
      S_FIN:   done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    row_base_d = row_base_q;
    pitch_d    = pitch_q;
    n_outer_d  = n_outer_q;
    n_inner_d  = n_inner_q;
    o_d        = o_q;
    i_d        = i_q;
    if (state_q == S_IDLE && start && !abort) begin
      row_base_d = base_addr;
      pitch_d    = pitch;
      n_outer_d  = n_outer;
      n_inner_d  = n_inner;
      o_d        = '0;
      i_d        = '0;
    end else if (issue) begin
      if (row_end) begin
        i_d        = '0;
        o_d        = o_q + CWIDTH'(1);
        row_base_d = row_base_q + pitch_q;
      end else begin
        i_d = i_q + CWIDTH'(1);
      end
    end
    // Tags ride alongside each read so they meet their ROM word at the buffer.
    vld_sr_d[0]   = issue;
    lasti_sr_d[0] = row_end;
    last_sr_d[0]  = win_end;
    for (int k = 1; k < MEM_LAT; k++) begin
      vld_sr_d[k]   = vld_sr_q[k-1];
      lasti_sr_d[k] = lasti_sr_q[k-1];
      last_sr_d[k]  = last_sr_q[k-1];
    end
    inflight_d = inflight_q + CW'(issue) - CW'(push);
    count_d    = count_q + CW'(push) - CW'(pop);
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    if (abort) begin
      vld_sr_d   = '0;
      inflight_d = '0;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_base_q <= '0;
      pitch_q    <= '0;
      n_outer_q  <= '0;
      n_inner_q  <= '0;
      o_q        <= '0;
      i_q        <= '0;
      vld_sr_q   <= '0;
      lasti_sr_q <= '0;
      last_sr_q  <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      row_base_q <= row_base_d;
      pitch_q    <= pitch_d;
      n_outer_q  <= n_outer_d;
      n_inner_q  <= n_inner_d;
      o_q        <= o_d;
      i_q        <= i_d;
      vld_sr_q   <= vld_sr_d;
      lasti_sr_q <= lasti_sr_d;
      last_sr_q  <= last_sr_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Buffer storage is data only; occupancy and pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {last_sr_q[MEM_LAT-1], lasti_sr_q[MEM_LAT-1], bus.mem_dout};
  end
endmodule

// File: tb/tb_param_stream.sv
// Scoreboard bench for param_stream: ROM model, address/word queues filled at start,
// drained by a negedge monitor that checks every ROM read and every accepted word.
module tb_param_stream;
  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int CWD   = 8;
  localparam int LAT   = 1;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start, abort;
  logic [AW-1:0]  base_addr, pitch;
  logic [CWD-1:0] n_outer, n_inner;
  logic           busy, done;

  param_stream_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  param_stream #(.DWIDTH(DW), .AWIDTH(AW), .CWIDTH(CWD), .MEM_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .pitch(pitch),
    .n_outer(n_outer), .n_inner(n_inner), .abort(abort), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {~a, a};
  endfunction

  logic [DW-1:0] rom_pipe [LAT];
  always @(posedge clk) begin
    if (bus.mem_en) rom_pipe[0] <= rom_word(bus.mem_addr);
    for (int k = 1; k < LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
  end
  assign bus.mem_dout = rom_pipe[LAT-1];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [AW-1:0]   addr_q [$];
  logic [DW+1:0]   exp_q  [$];
  int              issued = 0, accepted = 0, en_cnt = 0, valid_cnt = 0, done_cnt = 0;
  logic            hold_v = 1'b0;
  logic [DW+1:0]   hold_w;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_en) begin
        logic [AW-1:0] ea;
        en_cnt++;
        chk("credit", 64'((issued - accepted) < DEPTH), 64'd1);
        ea = (addr_q.size() != 0) ? addr_q.pop_front() : ~bus.mem_addr;
        chk("mem_addr", 64'(bus.mem_addr), 64'(ea));
        issued++;
      end
      if (hold_v) chk("stable", 64'({bus.out_valid, bus.out_last, bus.out_last_i, bus.out_data}),
                      64'({1'b1, hold_w}));
      hold_v = bus.out_valid && !bus.out_ready;
      hold_w = {bus.out_last, bus.out_last_i, bus.out_data};
      if (bus.out_valid) valid_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        logic [DW+1:0] ew;
        ew = (exp_q.size() != 0) ? exp_q.pop_front() : ~{bus.out_last, bus.out_last_i, bus.out_data};
        chk("out_word", 64'({bus.out_last, bus.out_last_i, bus.out_data}), 64'(ew));
        accepted++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic clear_sb();
    addr_q.delete();
    exp_q.delete();
    issued   = 0;
    accepted = 0;
    hold_v   = 1'b0;
  endtask

  task automatic push_exp(input logic [AW-1:0] b, input logic [AW-1:0] p, input int no, input int ni);
    for (int o = 0; o < no; o++)
      for (int i = 0; i < ni; i++) begin
        logic [AW-1:0] a;
        a = AW'(b + o * p + i);
        addr_q.push_back(a);
        exp_q.push_back({(o == no-1) && (i == ni-1), i == ni-1, rom_word(a)});
      end
  endtask

  task automatic set_ready(input int mode);
    case (mode)
      0: bus.out_ready = 1'b1;
      1: bus.out_ready = ~bus.out_ready;
      default: bus.out_ready = 1'b0;
    endcase
  endtask

  // Leaves start asserted; the next clocked wait deasserts it after one sampling edge.
  task automatic kick(input logic [AW-1:0] b, input logic [AW-1:0] p, input int no, input int ni);
    push_exp(b, p, no, ni);
    @(posedge clk); #1;
    base_addr = b; pitch = p; n_outer = CWD'(no); n_inner = CWD'(ni); start = 1'b1;
  endtask

  task automatic run_cycles(input int n, input int mode);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      set_ready(mode);
    end
  endtask

  task automatic wait_done(input int mode, input int budget, output int cyc);
    cyc = 0;
    while (cyc < budget) begin
      @(posedge clk); #1;
      start = 1'b0;
      set_ready(mode);
      cyc++;
      if (done) break;
    end
    chk("done_seen", 64'(done), 64'd1);
  endtask

  initial begin
    int cyc, d0, e0, v0, k;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    base_addr = '0; pitch = '0; n_outer = '0; n_inner = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_mem_en", 64'(bus.mem_en), 0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 0);
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_out_data", 64'(bus.out_data), 0);
    rst_n = 1'b1;

    // Basic 2x3 window, ready high: first-word latency, order, tags, single done.
    d0 = done_cnt;
    bus.out_ready = 1'b1;
    kick(16'd16, 16'd16, 2, 3);
    k = 0;
    while (k < 20) begin
      @(posedge clk); #1;
      start = 1'b0;
      k++;
      if (bus.out_valid) break;
    end
    chk("first_valid_lat", 64'(k - 1), 64'(LAT + 1));
    wait_done(0, 100, cyc);
    run_cycles(3, 0);
    chk("basic_done_once", 64'(done_cnt - d0), 1);
    chk("basic_drained", 64'(exp_q.size()), 0);

    // Same window with ready toggling every cycle.
    d0 = done_cnt;
    kick(16'd16, 16'd16, 2, 3);
    wait_done(1, 200, cyc);
    run_cycles(3, 0);
    chk("toggle_done_once", 64'(done_cnt - d0), 1);
    chk("toggle_drained", 64'(exp_q.size()), 0);

    // Downstream stalled: reads stop at the buffer depth, then resume in order.
    e0 = en_cnt;
    kick(16'd16, 16'd16, 2, 3);
    run_cycles(20, 2);
    chk("stall_reads", 64'(en_cnt - e0), 64'(DEPTH));
    chk("stall_busy", 64'(busy), 1);
    wait_done(0, 100, cyc);
    chk("stall_drained", 64'(exp_q.size()), 0);

    // Empty window: done without any read or output word.
    e0 = en_cnt; v0 = valid_cnt;
    kick(16'h0100, 16'd4, 3, 0);
    wait_done(0, 5, cyc);
    chk("zero_done_lat", 64'(cyc <= 2), 1);
    run_cycles(2, 0);
    chk("zero_no_reads", 64'(en_cnt - e0), 0);
    chk("zero_no_valid", 64'(valid_cnt - v0), 0);

    // Back-to-back: start during FIN is ignored, start in the following IDLE is taken.
    kick(16'h0040, 16'd8, 1, 2);
    wait_done(0, 50, cyc);
    push_exp(16'h0080, 16'd8, 1, 3);
    base_addr = 16'h0080; pitch = 16'd8; n_outer = 8'd1; n_inner = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    chk("b2b_fin_ignored", 64'(busy), 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_idle_taken", 64'(busy), 1);
    wait_done(0, 50, cyc);
    chk("b2b_drained", 64'(exp_q.size()), 0);

    // Abort with three words buffered and one read in flight.
    bus.out_ready = 1'b0;
    kick(16'h0300, 16'h0010, 2, 3);
    run_cycles(5, 2);
    chk("pre_abort_valid", 64'(bus.out_valid), 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    clear_sb();
    chk("abort_valid", 64'(bus.out_valid), 0);
    chk("abort_busy", 64'(busy), 0);
    chk("abort_done", 64'(done), 0);
    run_cycles(2, 0);
    kick(16'h0500, 16'd1, 2, 2);
    wait_done(0, 50, cyc);
    chk("post_abort_drained", 64'(exp_q.size()), 0);

    // Asynchronous reset in DRAIN, then an address window that wraps through zero.
    bus.out_ready = 1'b0;
    kick(16'h0200, 16'd0, 1, 4);
    run_cycles(8, 2);
    chk("drain_busy", 64'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 0);
    chk("arst_mem_en", 64'(bus.mem_en), 0);
    chk("arst_mem_addr", 64'(bus.mem_addr), 0);
    chk("arst_valid", 64'(bus.out_valid), 0);
    chk("arst_data", 64'({bus.out_last, bus.out_last_i, bus.out_data}), 0);
    @(posedge clk); #1;
    clear_sb();
    rst_n = 1'b1;
    kick(16'h0001, 16'hFFFF, 3, 2);
    wait_done(0, 50, cyc);
    chk("wrap_drained", 64'(exp_q.size()), 0);
    run_cycles(2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
